// File: rtl/cpu_ctrl_pkg.sv
// ============================================================================
// Module : cpu_ctrl_pkg
// Brief  : Shared state encodings, datapath select codes and opcodes for the
//          multi-cycle control unit.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_EXEC_R   = 4'd2,
    ST_R_WB     = 4'd3,
    ST_EXEC_I   = 4'd4,
    ST_I_WB     = 4'd5,
    ST_MEM_ADDR = 4'd6,
    ST_MEM_RD   = 4'd7,
    ST_MEM_WB   = 4'd8,
    ST_MEM_WR   = 4'd9,
    ST_BRANCH   = 4'd10,
    ST_JUMP     = 4'd11
  } state_t;

  localparam logic [1:0] ALU_ADD      = 2'b00;
  localparam logic [1:0] ALU_SUB      = 2'b01;
  localparam logic [1:0] ALU_FUNCT    = 2'b10;
  localparam logic [1:0] ALU_LOGIC    = 2'b11;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [5:0] OP_RTYPE     = 6'b000000;
  localparam logic [5:0] OP_ANDI      = 6'b001100;
  localparam logic [5:0] OP_ORI       = 6'b001101;
  localparam logic [5:0] OP_STORE     = 6'b010000;
  localparam logic [5:0] OP_LOAD      = 6'b010001;
  localparam logic [5:0] OP_BRANCH    = 6'b010011;
  localparam logic [5:0] OP_JUMP      = 6'b011100;

  function automatic logic is_mem_state(input state_t s);
    return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_wait_timer.sv
// ============================================================================
// Module : mem_wait_timer
// Brief  : Counts stalled memory cycles and flags a timeout at 2^WAIT_W-1.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_wait_timer #(
  parameter int WAIT_W = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic waiting,
  input  logic ready,
  output logic timeout
);

  // The cycle that would bring the count up to the limit is the one that times out.
  localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'((1 << WAIT_W) - 2);

  logic [WAIT_W-1:0] cnt_q;
  logic [WAIT_W-1:0] cnt_d;

  assign timeout = waiting && !ready && (cnt_q == LAST_WAIT);

  always_comb begin
    cnt_d = cnt_q;
    if (clear || timeout) begin
      cnt_d = '0;
    end else if (waiting && !ready) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/multi_cycle_control.sv
// ============================================================================
// Module : multi_cycle_control
// Brief  : Moore-style multi-cycle CPU control FSM with memory handshake and
//          stall timeout.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multi_cycle_control
  import cpu_ctrl_pkg::*;
#(
  parameter int OPCODE_W      = 6,
  parameter int MEM_HANDSHAKE = 1,
  parameter int WAIT_W        = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic                ir_write,
  output logic                i_or_d,
  output logic                mem_read,
  output logic                mem_write,
  output logic                reg_write,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          alu_op,
  output logic                alu_logic_or,
  output logic [1:0]          pc_source,
  output logic                illegal_op,
  output logic                mem_timeout,
  output logic [3:0]          state
);

  state_t              state_q;
  state_t              state_d;
  logic [OPCODE_W-1:0] opcode_q;
  logic                illegal_q;
  logic                illegal_d;
  logic                timeout_q;

  logic w_waiting;
  logic w_mem_done;
  logic w_timeout;
  logic w_clear;

  assign w_waiting  = (MEM_HANDSHAKE != 0) && is_mem_state(state_q);
  assign w_mem_done = (MEM_HANDSHAKE == 0) || mem_ready;
  assign w_clear    = (state_d != state_q);

  mem_wait_timer #(
    .WAIT_W (WAIT_W)
  ) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (w_clear),
    .waiting (w_waiting),
    .ready   (mem_ready),
    .timeout (w_timeout)
  );

  always_comb begin
    state_d       = state_q;
    illegal_d     = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    ir_write      = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REG;
    alu_op        = ALU_ADD;
    alu_logic_or  = 1'b0;
    pc_source     = PCSRC_ALU;

    case (state_q)
      ST_FETCH: begin
        mem_read  = 1'b1;
        ir_write  = 1'b1;
        alu_src_b = SRCB_FOUR;
        // PC only advances on the cycle the instruction word actually arrives.
        if (w_mem_done) begin
          pc_write = 1'b1;
          state_d  = ST_DECODE;
        end
      end
      ST_DECODE: begin
        alu_src_b = SRCB_IMM_SH2;
        case (opcode)
          OPCODE_W'(OP_RTYPE):                     state_d = ST_EXEC_R;
          OPCODE_W'(OP_ANDI), OPCODE_W'(OP_ORI):   state_d = ST_EXEC_I;
          OPCODE_W'(OP_STORE), OPCODE_W'(OP_LOAD): state_d = ST_MEM_ADDR;
          OPCODE_W'(OP_BRANCH):                    state_d = ST_BRANCH;
          OPCODE_W'(OP_JUMP):                      state_d = ST_JUMP;
          default: begin
            state_d   = ST_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      ST_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
        state_d   = ST_R_WB;
      end
      ST_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_d   = ST_FETCH;
      end
      ST_EXEC_I: begin
        alu_src_a    = 1'b1;
        alu_src_b    = SRCB_IMM;
        alu_op       = ALU_LOGIC;
        alu_logic_or = opcode_q[0];
        state_d      = ST_I_WB;
      end
      ST_I_WB: begin
        reg_write = 1'b1;
        state_d   = ST_FETCH;
      end
      ST_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = (opcode_q == OPCODE_W'(OP_LOAD)) ? ST_MEM_RD : ST_MEM_WR;
      end
      ST_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (w_mem_done) begin
          state_d = ST_MEM_WB;
        end else if (w_timeout) begin
          state_d = ST_FETCH;
        end
      end
      ST_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = ST_FETCH;
      end
      ST_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (w_mem_done || w_timeout) begin
          state_d = ST_FETCH;
        end
      end
      ST_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
        state_d       = ST_FETCH;
      end
      ST_JUMP: begin
        pc_write  = 1'b1;
        pc_source = PCSRC_JUMP;
        state_d   = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_FETCH;
      opcode_q  <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      if (state_q == ST_DECODE) begin
        opcode_q <= opcode;
      end
      illegal_q <= illegal_d;
      timeout_q <= w_timeout;
    end
  end

  assign illegal_op  = illegal_q;
  assign mem_timeout = timeout_q;
  assign state       = state_q;

endmodule

`default_nettype wire

// File: tb/tb_multi_cycle_control.sv
// ============================================================================
// Module : tb_multi_cycle_control
// Brief  : Directed self-checking bench for multi_cycle_control (three configs).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multi_cycle_control;
  import cpu_ctrl_pkg::*;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, pcwc, irw, iord, mrd, mwr, rw, rdst, m2r, asa;
    logic [1:0] asb, aop;
    logic       lor;
    logic [1:0] pcs;
    logic       ill, tmo;
  } out_t;

  logic       clk       = 1'b0;
  logic       rst_n     = 1'b0;
  logic [5:0] opcode    = 6'h00;
  logic       mem_ready = 1'b0;

  out_t o0, o1, o2, act;
  int   sel      = 0;
  int   checks   = 0;
  int   failures = 0;
  int   ill_seen = 0;
  int   tmo_seen = 0;
  int   ncyc     = 0;
  logic pend_ill = 1'b0;
  logic pend_tmo = 1'b0;
  int   hs_cfg  [3] = '{1, 1, 0};
  int   lim_cfg [3] = '{15, 3, 1};

  always #5 clk = ~clk;

  multi_cycle_control #(.OPCODE_W(6), .MEM_HANDSHAKE(1), .WAIT_W(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(o0.pcw), .pc_write_cond(o0.pcwc), .ir_write(o0.irw), .i_or_d(o0.iord),
    .mem_read(o0.mrd), .mem_write(o0.mwr), .reg_write(o0.rw), .reg_dst(o0.rdst),
    .mem_to_reg(o0.m2r), .alu_src_a(o0.asa), .alu_src_b(o0.asb), .alu_op(o0.aop),
    .alu_logic_or(o0.lor), .pc_source(o0.pcs), .illegal_op(o0.ill),
    .mem_timeout(o0.tmo), .state(o0.st)
  );

  multi_cycle_control #(.OPCODE_W(6), .MEM_HANDSHAKE(1), .WAIT_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(o1.pcw), .pc_write_cond(o1.pcwc), .ir_write(o1.irw), .i_or_d(o1.iord),
    .mem_read(o1.mrd), .mem_write(o1.mwr), .reg_write(o1.rw), .reg_dst(o1.rdst),
    .mem_to_reg(o1.m2r), .alu_src_a(o1.asa), .alu_src_b(o1.asb), .alu_op(o1.aop),
    .alu_logic_or(o1.lor), .pc_source(o1.pcs), .illegal_op(o1.ill),
    .mem_timeout(o1.tmo), .state(o1.st)
  );

  multi_cycle_control #(.OPCODE_W(6), .MEM_HANDSHAKE(0), .WAIT_W(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(o2.pcw), .pc_write_cond(o2.pcwc), .ir_write(o2.irw), .i_or_d(o2.iord),
    .mem_read(o2.mrd), .mem_write(o2.mwr), .reg_write(o2.rw), .reg_dst(o2.rdst),
    .mem_to_reg(o2.m2r), .alu_src_a(o2.asa), .alu_src_b(o2.asb), .alu_op(o2.aop),
    .alu_logic_or(o2.lor), .pc_source(o2.pcs), .illegal_op(o2.ill),
    .mem_timeout(o2.tmo), .state(o2.st)
  );

  always_comb begin
    case (sel)
      0:       act = o0;
      1:       act = o1;
      default: act = o2;
    endcase
  end

  // Output table for each control step, straight from the per-state strobe list.
  function automatic out_t fsm_outputs(input state_t s, input logic done, input logic lor);
    out_t e = '0;
    e.st = s;
    case (s)
      ST_FETCH:    begin e.mrd = 1'b1; e.irw = 1'b1; e.asb = 2'b01; e.pcw = done; end
      ST_DECODE:   e.asb = 2'b11;
      ST_EXEC_R:   begin e.asa = 1'b1; e.asb = 2'b00; e.aop = 2'b10; end
      ST_R_WB:     begin e.rw = 1'b1; e.rdst = 1'b1; end
      ST_EXEC_I:   begin e.asa = 1'b1; e.asb = 2'b10; e.aop = 2'b11; e.lor = lor; end
      ST_I_WB:     e.rw = 1'b1;
      ST_MEM_ADDR: begin e.asa = 1'b1; e.asb = 2'b10; end
      ST_MEM_RD:   begin e.mrd = 1'b1; e.iord = 1'b1; end
      ST_MEM_WB:   begin e.rw = 1'b1; e.m2r = 1'b1; end
      ST_MEM_WR:   begin e.mwr = 1'b1; e.iord = 1'b1; end
      ST_BRANCH:   begin e.asa = 1'b1; e.aop = 2'b01; e.pcwc = 1'b1; e.pcs = 2'b01; end
      ST_JUMP:     begin e.pcw = 1'b1; e.pcs = 2'b10; end
      default:     e = '0;
    endcase
    return e;
  endfunction

  // One clock of the model: drive inputs, compare mid-cycle, advance.
  task automatic step(input state_t s, input logic done, input logic rdy,
                      input logic [5:0] op, input logic lor);
    out_t e;
    mem_ready = rdy;
    opcode    = op;
    e         = fsm_outputs(s, done, lor);
    e.ill     = pend_ill;
    e.tmo     = pend_tmo;
    pend_ill  = 1'b0;
    pend_tmo  = 1'b0;
    @(negedge clk);
    checks++;
    if (act !== e) begin
      failures++;
      $display("FAIL outputs sel=%0d want_state=%0d got=%h want=%h", sel, e.st, act, e);
    end
    ill_seen += int'(act.ill);
    tmo_seen += int'(act.tmo);
    @(posedge clk);
    #1;
    ncyc++;
  endtask

  task automatic mem_phase(input state_t s, input int waits, input logic [5:0] op,
                           output logic ok);
    ok = 1'b0;
    if (hs_cfg[sel] == 0) begin
      step(s, 1'b1, 1'b0, op, 1'b0);
      ok = 1'b1;
      return;
    end
    for (int k = 0; k < lim_cfg[sel]; k++) begin
      if (k >= waits) begin
        step(s, 1'b1, 1'b1, op, 1'b0);
        ok = 1'b1;
        return;
      end
      step(s, 1'b0, 1'b0, op, 1'b0);
    end
    pend_tmo = 1'b1;
  endtask

  // Whole instruction: wf / wm are stall cycles before mem_ready in fetch / data access.
  task automatic run_instr(input logic [5:0] op, input int wf, input int wm, output int n);
    logic       ok;
    logic [5:0] nop;
    nop  = ~op;
    ncyc = 0;
    mem_phase(ST_FETCH, wf, nop, ok);
    if (ok) begin
      step(ST_DECODE, 1'b0, 1'b1, op, 1'b0);
      case (op)
        6'b000000: begin
          step(ST_EXEC_R, 1'b0, 1'b1, nop, 1'b0);
          step(ST_R_WB, 1'b0, 1'b1, nop, 1'b0);
        end
        6'b001100, 6'b001101: begin
          step(ST_EXEC_I, 1'b0, 1'b1, nop, op[0]);
          step(ST_I_WB, 1'b0, 1'b1, nop, 1'b0);
        end
        6'b010001: begin
          step(ST_MEM_ADDR, 1'b0, 1'b1, nop, 1'b0);
          mem_phase(ST_MEM_RD, wm, nop, ok);
          if (ok) step(ST_MEM_WB, 1'b0, 1'b1, nop, 1'b0);
        end
        6'b010000: begin
          step(ST_MEM_ADDR, 1'b0, 1'b1, nop, 1'b0);
          mem_phase(ST_MEM_WR, wm, nop, ok);
        end
        6'b010011: step(ST_BRANCH, 1'b0, 1'b1, nop, 1'b0);
        6'b011100: step(ST_JUMP, 1'b0, 1'b1, nop, 1'b0);
        default:   pend_ill = 1'b1;
      endcase
    end
    n = ncyc;
  endtask

  task automatic check_int(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic do_reset(input int s);
    rst_n     = 1'b0;
    mem_ready = 1'b0;
    opcode    = 6'h2A;
    sel       = s;
    pend_ill  = 1'b0;
    pend_tmo  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog sim time exceeded got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    int n;
    int base;

    // ---------------- default config ----------------
    rst_n = 1'b0;
    sel   = 0;
    #13;
    check_int("rst_state", int'(act.st), int'(ST_FETCH));
    check_int("rst_mem_read", int'(act.mrd), 1);
    check_int("rst_ir_write", int'(act.irw), 1);
    check_int("rst_alu_src_b", int'(act.asb), 1);
    check_int("rst_pc_write", int'(act.pcw), 0);
    check_int("rst_error_pulses", int'(act.ill) + int'(act.tmo), 0);
    do_reset(0);

    run_instr(6'b000000, 0, 0, n); check_int("lat_rtype", n, 4);
    run_instr(6'b001100, 0, 0, n); check_int("lat_andi", n, 4);
    run_instr(6'b001101, 0, 0, n); check_int("lat_ori", n, 4);
    run_instr(6'b010001, 0, 0, n); check_int("lat_load", n, 5);
    run_instr(6'b010001, 0, 3, n); check_int("lat_load_stall3", n, 8);
    run_instr(6'b010000, 0, 0, n); check_int("lat_store", n, 4);
    run_instr(6'b010011, 0, 0, n); check_int("lat_branch", n, 3);
    run_instr(6'b011100, 0, 0, n); check_int("lat_jump", n, 3);
    base = ill_seen;
    run_instr(6'b111111, 0, 0, n); check_int("lat_illegal", n, 2);
    run_instr(6'b010010, 0, 0, n); check_int("lat_illegal_near_load", n, 2);
    run_instr(6'b000000, 2, 0, n); check_int("lat_rtype_fetch_stall2", n, 6);
    check_int("illegal_pulse_count", ill_seen - base, 2);

    // ---------------- WAIT_W=2 config ----------------
    do_reset(1);
    base = tmo_seen;
    run_instr(6'b010000, 0, 99, n); check_int("lat_store_timeout", n, 6);
    run_instr(6'b010000, 0, 2, n);  check_int("lat_store_ready_at_limit", n, 6);
    run_instr(6'b000000, 99, 0, n); check_int("lat_fetch_timeout", n, 3);
    run_instr(6'b000000, 0, 0, n);  check_int("lat_rtype_after_timeout", n, 4);
    check_int("timeout_pulse_count", tmo_seen - base, 2);

    step(ST_FETCH, 1'b1, 1'b1, 6'h00, 1'b0);
    step(ST_DECODE, 1'b0, 1'b1, 6'b010000, 1'b0);
    step(ST_MEM_ADDR, 1'b0, 1'b1, 6'h00, 1'b0);
    step(ST_MEM_WR, 1'b0, 1'b0, 6'h00, 1'b0);
    mem_ready = 1'b0;
    #2;
    check_int("pre_reset_mem_write", int'(act.mwr), 1);
    rst_n = 1'b0;
    #1;
    check_int("async_rst_state", int'(act.st), int'(ST_FETCH));
    check_int("async_rst_mem_write", int'(act.mwr), 0);
    check_int("async_rst_mem_read", int'(act.mrd), 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    base = tmo_seen;
    run_instr(6'b010000, 0, 2, n); check_int("lat_store_after_reset", n, 6);
    run_instr(6'b000000, 0, 0, n); check_int("lat_rtype_after_reset", n, 4);
    check_int("no_timeout_after_reset", tmo_seen - base, 0);

    // ---------------- MEM_HANDSHAKE=0 config ----------------
    do_reset(2);
    run_instr(6'b010001, 5, 5, n); check_int("lat_load_nohs", n, 5);
    run_instr(6'b010000, 5, 5, n); check_int("lat_store_nohs", n, 4);
    run_instr(6'b011100, 5, 5, n); check_int("lat_jump_nohs", n, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/multi_cycle_control.md
MULTI_CYCLE_CONTROL -- requirements
Module: multi_cycle_control

Interface
REQ-001 SHALL have parameter OPCODE_W, default 6, opcode field width.
REQ-002 SHALL have parameter MEM_HANDSHAKE, default 1; 1 = memory states wait for mem_ready, 0 = memory completes in one cycle.
REQ-003 SHALL have parameter WAIT_W, default 4, width of memory-wait counter; timeout limit = 2^WAIT_W-1 cycles.
REQ-004 SHALL have one clock and an asynchronous active-low reset: clk input 1 (rising-edge clock); rst_n input 1 (async assert, active low).
REQ-005 opcode  input  OPCODE_W  instruction opcode, sampled in DECODE only.
REQ-006 mem_ready  input  1  memory access complete this cycle.
REQ-007 pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write, reg_write, reg_dst, mem_to_reg, alu_src_a  output  1 each  datapath strobes/selects.
REQ-008 alu_src_b  output  2  00 reg B, 01 constant 4, 10 sign-ext imm, 11 imm<<2.
REQ-009 alu_op  output  2  00 add, 01 sub, 10 funct-decoded, 11 logic-immediate.
REQ-010 alu_logic_or  output  1  with alu_op=11: 0 AND, 1 OR.
REQ-011 pc_source  output  2  00 ALU result, 01 ALUOut, 10 jump target.
REQ-012 illegal_op, mem_timeout  output  1 each  one-cycle error pulses.
REQ-013 state  output  4  current FSM state encoding.

Function
REQ-014 SHALL implement a Moore FSM; every output except the error pulses is a function of state (and latched opcode bit 0 for alu_logic_or) only; unlisted outputs are 0 in each state.
REQ-015 FETCH: mem_read=1, i_or_d=0, ir_write=1, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00, pc_write=1 on completing cycle only; -> DECODE on completion.
REQ-016 DECODE: alu_src_a=0, alu_src_b=11, alu_op=00; latch opcode; next state: 000000 EXEC_R, 001100/001101 EXEC_I, 010000/010001 MEM_ADDR, 010011 BRANCH, 011100 JUMP, any other -> FETCH with illegal_op pulsed one cycle.
REQ-017 EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10; -> R_WB.
REQ-018 R_WB: reg_write=1, reg_dst=1, mem_to_reg=0; -> FETCH.
REQ-019 EXEC_I: alu_src_a=1, alu_src_b=10, alu_op=11, alu_logic_or=latched opcode[0]; -> I_WB.
REQ-020 I_WB: reg_write=1, reg_dst=0, mem_to_reg=0; -> FETCH.
REQ-021 MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00; -> MEM_RD if load (010001), MEM_WR if store (010000).
REQ-022 MEM_RD: mem_read=1, i_or_d=1; -> MEM_WB on completion.
REQ-023 MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1; -> FETCH.
REQ-024 MEM_WR: mem_write=1, i_or_d=1; -> FETCH on completion.
REQ-025 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01; -> FETCH.
REQ-026 JUMP: pc_write=1, pc_source=10; -> FETCH.
REQ-027 Completion in FETCH/MEM_RD/MEM_WR: MEM_HANDSHAKE=0 -> first cycle; MEM_HANDSHAKE=1 -> cycle where mem_ready=1; state and strobes held while waiting.
REQ-028 Wait counter clears on entry to each memory state, increments per waiting cycle; on reaching 2^WAIT_W-1 without mem_ready, pulse mem_timeout one cycle and go to FETCH (no pc_write, no reg_write); mem_ready in the same cycle as the limit wins (normal completion).
REQ-029 Latencies with mem_ready=1 every cycle: R/I 4 cycles, load 5, store 4, branch 3, jump 3.
REQ-030 mem_ready outside memory states SHALL be ignored.

Reset
REQ-031 rst_n low SHALL asynchronously force state=FETCH, wait counter=0, latched opcode=0, illegal_op=0, mem_timeout=0.
REQ-032 During and immediately after reset, outputs SHALL equal FETCH-state values (mem_read=1, ir_write=1, alu_src_b=01, pc_write=0 until completion); reset mid-instruction abandons it with no further writes.

Structure
REQ-033 State encodings, alu_op, alu_src_b, pc_source codes and opcode constants SHALL live in a shared package (cpu_ctrl_pkg).
REQ-034 Wait counter/timeout SHALL be sub-module mem_wait_timer (inputs clear, waiting, ready; output timeout).

Verification
REQ-035 MEM_HANDSHAKE=1, mem_ready tied 1, opcode 000000 -> states FETCH,DECODE,EXEC_R,R_WB, reg_write=1 with reg_dst=1 in cycle 4.
REQ-036 Load 010001, mem_ready low 3 cycles in MEM_RD -> MEM_RD held 4 cycles, mem_to_reg=1 reg_write=1 next, total 8 cycles.
REQ-037 Opcode 111111 -> illegal_op one-cycle pulse, return to FETCH after DECODE, no reg_write/mem_write.
REQ-038 WAIT_W=2, store, mem_ready held 0 -> mem_timeout after 3 waiting cycles, next FETCH, mem_write drops.
REQ-039 rst_n asserted in MEM_WR mid-wait -> immediate FETCH, mem_write=0 same cycle, counter 0.
REQ-040 Opcode 001101 -> alu_op=11, alu_logic_or=1 in EXEC_I; 001100 -> alu_logic_or=0.
